beep_scheduler: RTL and testbench

Sequencer and arbiter for the tone output. It drives the s_enable/sonido pair the audio path consumes. Three requesters can ask for a sound: key click (short), error (long) and alarm (burst of beeps). The block latches the requests, grants them one at a time by fixed priority, and times each tone and its trailing silent gap from an external tick strobe.

---
 rtl/beep_scheduler.sv | 140 ++++++++++++++
 tb/tb_beep_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/beep_scheduler.sv
// Tone sequencer/arbiter: latches short/long/alarm requests, grants one at a time
// (alarm > long > short) and times each tone plus its trailing gap from a tick strobe.
module beep_scheduler #(
  parameter int unsigned FW          = 52,
  parameter int unsigned SHORT_TICKS = 50,
  parameter int unsigned LONG_TICKS  = 400,
  parameter int unsigned GAP_TICKS   = 100,
  parameter int unsigned ALARM_BEEPS = 3,
  parameter int unsigned FREQ_SHORT  = 32000,
  parameter int unsigned FREQ_LONG   = 32000,
  parameter int unsigned FREQ_ALARM  = 48000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          tick,
  input  logic          req_short,
  input  logic          req_long,
  input  logic          req_alarm,
  output logic          s_enable,
  output logic [FW-1:0] sonido,
  output logic          busy,
  output logic          done
);

  localparam int unsigned MaxTone  = (LONG_TICKS > SHORT_TICKS) ? LONG_TICKS : SHORT_TICKS;
  localparam int unsigned MaxTicks = (MaxTone > GAP_TICKS) ? MaxTone : GAP_TICKS;
  localparam int unsigned CW       = $clog2(MaxTicks + 1);
  localparam int unsigned BW       = $clog2(ALARM_BEEPS + 1);

  typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beep_q, beep_d;
  logic [2:0]    pend_q, pend_d;   // {alarm, long, short}
  logic [2:0]    grant;
  logic          sen_q, sen_d;
  logic [FW-1:0] sonido_q, sonido_d;
  logic          done_q, done_d;

  always_comb begin
    grant = 3'b000;
    if (enable && state_q == StIdle) begin
      if (pend_q[2])      grant = 3'b100;
      else if (pend_q[1]) grant = 3'b010;
      else if (pend_q[0]) grant = 3'b001;
    end
    // A same-cycle request of the granted class re-arms its bit.
    pend_d = (pend_q & ~grant) | {req_alarm, req_long, req_short};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beep_d   = beep_q;
    sen_d    = sen_q;
    sonido_d = sonido_q;
    done_d   = 1'b0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (grant != 3'b000) begin
            state_d = StTone;
            sen_d   = 1'b1;
            if (grant[2]) begin
              cnt_d    = CW'(SHORT_TICKS);
              beep_d   = BW'(ALARM_BEEPS);
              sonido_d = FW'(FREQ_ALARM);
            end else if (grant[1]) begin
              cnt_d    = CW'(LONG_TICKS);
              beep_d   = BW'(1);
              sonido_d = FW'(FREQ_LONG);
            end else begin
              cnt_d    = CW'(SHORT_TICKS);
              beep_d   = BW'(1);
              sonido_d = FW'(FREQ_SHORT);
            end
          end
        end
        StTone: begin
          if (tick) begin
            if (cnt_q == CW'(1)) begin
              state_d  = StGap;
              cnt_d    = CW'(GAP_TICKS);
              beep_d   = beep_q - BW'(1);
              sen_d    = 1'b0;
              sonido_d = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        StGap: begin
          if (tick) begin
            if (cnt_q != CW'(1)) begin
              cnt_d = cnt_q - CW'(1);
            end else if (beep_q != '0) begin
              // Only an alarm burst carries more than one beep.
              state_d  = StTone;
              cnt_d    = CW'(SHORT_TICKS);
              sen_d    = 1'b1;
              sonido_d = FW'(FREQ_ALARM);
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      beep_q   <= '0;
      pend_q   <= '0;
      sen_q    <= 1'b0;
      sonido_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beep_q   <= beep_d;
      pend_q   <= pend_d;
      sen_q    <= sen_d;
      sonido_q <= sonido_d;
      done_q   <= done_d;
    end
  end

  assign s_enable = sen_q;
  assign sonido   = sonido_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench for beep_scheduler: stimulus queues expected tones, a monitor
// measures each tone/gap in ticks and checks frequency, lengths and done pulses.
module tb_beep_scheduler;

  localparam int unsigned FW    = 52;
  localparam int unsigned ShortT = 4;
  localparam int unsigned LongT  = 6;
  localparam int unsigned GapT   = 2;
  localparam int unsigned Beeps  = 3;
  localparam int unsigned FShort = 32000;
  localparam int unsigned FLong  = 32000;
  localparam int unsigned FAlarm = 48000;

  logic          clk = 1'b0;
  logic          reset_n, enable, tick, req_short, req_long, req_alarm;
  logic          s_enable, busy, done;
  logic [FW-1:0] sonido;

  typedef struct {
    int unsigned freq;
    int unsigned ticks;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   in_tone = 0, in_gap = 0;
  int   tcount = 0, gcount = 0;

  beep_scheduler #(
    .FW(FW), .SHORT_TICKS(ShortT), .LONG_TICKS(LongT), .GAP_TICKS(GapT),
    .ALARM_BEEPS(Beeps), .FREQ_SHORT(FShort), .FREQ_LONG(FLong), .FREQ_ALARM(FAlarm)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tick(tick),
    .req_short(req_short), .req_long(req_long), .req_alarm(req_alarm),
    .s_enable(s_enable), .sonido(sonido), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned f, input int unsigned t, input bit l);
    exp_t e;
    e.freq = f; e.ticks = t; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_alarm();
    for (int i = 0; i < int'(Beeps); i++) push(FAlarm, ShortT, i == int'(Beeps) - 1);
  endtask

  task automatic pulse(input logic s, input logic l, input logic a);
    @(posedge clk); #1;
    req_short = s; req_long = l; req_alarm = a;
    @(posedge clk); #1;
    req_short = 0; req_long = 0; req_alarm = 0;
  endtask

  task automatic wait_tone(input string name);
    int n;
    n = 0;
    while (!s_enable && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_enable) begin
      checks++; errors++;
      $display("FAIL %s: timeout got s_enable=0 expected 1", name);
    end
  endtask

  task automatic wait_done(input string name, input int want);
    int n, seen;
    n = 0; seen = 0;
    while (seen < want && n < 3000) begin
      @(negedge clk);
      if (done) seen++;
      n++;
    end
    check({name, "_done_count"}, seen, want);
    repeat (4) @(posedge clk);
    #1 check({name, "_idle"}, busy, 0);
  endtask

  // Timebase: one tick strobe every 5 clocks.
  initial begin
    tick = 0;
    forever begin
      repeat (4) @(posedge clk);
      #1 tick = 1;
      @(posedge clk);
      #1 tick = 0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_tone = 0; in_gap = 0; tcount = 0; gcount = 0;
      end else begin
        if (done) begin
          check("done_in_gap", in_gap, 1);
          check("done_gap_ticks", gcount, GapT);
          check("done_expected", cur.last, 1);
          check("done_busy", busy, 0);
          in_gap = 0;
        end
        if (s_enable && !in_tone) begin
          if (in_gap) begin
            check("gap_ticks", gcount, GapT);
            check("gap_not_last", cur.last, 0);
          end
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tone: got sonido=%0d expected no tone", sonido);
            cur.freq = 0; cur.ticks = 0; cur.last = 0;
          end else begin
            cur = exp_q.pop_front();
            check("tone_freq", sonido, cur.freq);
          end
          in_tone = 1; in_gap = 0; tcount = 0;
        end else if (!s_enable && in_tone) begin
          check("tone_ticks", tcount, cur.ticks);
          check("gap_silent", sonido, 0);
          in_tone = 0; in_gap = 1; gcount = 0;
        end
        if (enable && tick) begin
          if (in_tone) tcount++;
          if (in_gap)  gcount++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; enable = 1; req_short = 0; req_long = 1; req_alarm = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_enable", s_enable, 0);
    check("rst_sonido", sonido, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1; req_long = 0;
    repeat (30) @(posedge clk);
    #1;
    check("idle_after_rst_busy", busy, 0);
    check("idle_after_rst_sen", s_enable, 0);

    // Single short beep with request-to-tone latency.
    push(FShort, ShortT, 1);
    pulse(1, 0, 0);
    check("lat_edge_k_sen", s_enable, 0);
    @(posedge clk); #1;
    check("lat_edge_k1_sen", s_enable, 1);
    check("lat_edge_k1_sonido", sonido, FShort);
    check("lat_edge_k1_busy", busy, 1);
    wait_done("short", 1);

    // Alarm burst.
    push_alarm();
    pulse(0, 0, 1);
    wait_done("alarm", 1);

    // Simultaneous requests served alarm, long, short.
    push_alarm();
    push(FLong, LongT, 1);
    push(FShort, ShortT, 1);
    pulse(1, 1, 1);
    wait_done("all3", 3);

    // Repeated short requests during a long tone merge into one.
    push(FLong, LongT, 1);
    push(FShort, ShortT, 1);
    pulse(0, 1, 0);
    wait_tone("merge_tone");
    repeat (3) begin
      repeat (3) @(posedge clk);
      pulse(1, 0, 0);
    end
    wait_done("merge", 2);

    // Freeze mid-tone for 20 ticks.
    push(FLong, LongT, 1);
    pulse(0, 1, 0);
    wait_tone("freeze_tone");
    repeat (8) @(posedge clk);
    #1 enable = 0;
    repeat (10) begin
      repeat (10) @(posedge clk);
      #1;
      check("freeze_sen", s_enable, 1);
      check("freeze_sonido", sonido, FLong);
    end
    enable = 1;
    wait_done("freeze", 1);

    check("queue_empty", exp_q.size(), 0);

    // Reset mid-tone silences on the reset edge.
    push(FShort, ShortT, 1);
    pulse(1, 0, 0);
    wait_tone("rst_mid_tone");
    @(posedge clk); #1 reset_n = 0;
    @(posedge clk); #1;
    check("rst_mid_sen", s_enable, 0);
    check("rst_mid_sonido", sonido, 0);
    check("rst_mid_busy", busy, 0);
    reset_n = 1;
    repeat (40) @(posedge clk);
    #1 check("rst_mid_stays_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
